// File: rtl/grid_pkg.sv
// Shared types and defaults for the grid shift store.
// Exports: dir_e direction codes, DEFAULT_ROWS/COLS, COUNT_W.
package grid_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam int DEFAULT_ROWS = 8;
    localparam int DEFAULT_COLS = 8;

    // Wide enough for a full 16x16 grid (256).
    localparam int COUNT_W = 9;

endpackage

// File: rtl/grid_shift_store_if.sv
// Command/status bundle of the grid shift store.
// master: drives clear/shift/set, reads grid and status; slave: the store.
interface grid_shift_store_if
    import grid_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS
);
    logic                   clear;
    logic                   shift_en;
    logic [1:0]             shift_dir;
    logic                   set;
    logic [3:0]             set_row;
    logic [3:0]             set_col;
    logic                   set_value;
    logic [ROWS*COLS-1:0]   data_out;
    logic [COLS-1:0]        out_up;
    logic [COLS-1:0]        out_down;
    logic [ROWS-1:0]        out_left;
    logic [ROWS-1:0]        out_right;
    logic [COUNT_W-1:0]     ones_count;
    logic                   collision;
    logic                   lost;
    logic                   addr_err;

    modport master (
        output clear, shift_en, shift_dir,
        output set, set_row, set_col, set_value,
        input  data_out, out_up, out_down,
        input  out_left, out_right, ones_count,
        input  collision, lost, addr_err
    );

    modport slave (
        input  clear, shift_en, shift_dir,
        input  set, set_row, set_col, set_value,
        output data_out, out_up, out_down,
        output out_left, out_right, ones_count,
        output collision, lost, addr_err
    );

endinterface

// File: rtl/grid_popcount.sv
// Combinational population count of a W-bit vector.
// Ports: bits_i (W) in, count_o (CW) number of set bits.
module grid_popcount #(
    parameter int W  = 64,
    parameter int CW = 9
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/grid_shift_store.sv
// ROWS x COLS bit grid with clear, one-step shift and single-cell write.
// Ports: clk, reset (async active-low), bus (grid_shift_store_if.slave).
module grid_shift_store
    import grid_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS,
    parameter bit WRAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    grid_shift_store_if.slave bus
);

    localparam int N = ROWS * COLS;

    logic [N-1:0]    grid_q, grid_d;
    logic [N-1:0]    shifted;
    logic [COLS-1:0] out_up_q, out_up_d;
    logic [COLS-1:0] out_down_q, out_down_d;
    logic [ROWS-1:0] out_left_q, out_left_d;
    logic [ROWS-1:0] out_right_q, out_right_d;
    logic            collision_q, collision_d;
    logic            lost_q, lost_d;
    logic            addr_err_q, addr_err_d;

    logic [COLS-1:0] top_row, bot_row;
    logic [ROWS-1:0] left_col, right_col;
    logic            discard_nz;
    logic            in_range;
    logic            hit;
    logic            do_shift;
    logic            do_set;

    // Edge lines of the current grid: the candidates for being shifted out.
    always_comb begin
        top_row = grid_q[0 +: COLS];
        bot_row = grid_q[(ROWS-1)*COLS +: COLS];
        left_col  = '0;
        right_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            left_col[r]  = grid_q[r*COLS];
            right_col[r] = grid_q[r*COLS + COLS - 1];
        end
    end

    assign do_shift = bus.shift_en & ~bus.clear;
    assign do_set   = bus.set & ~bus.clear;

    assign in_range = ({1'b0, bus.set_row} < 5'(ROWS))
                    && ({1'b0, bus.set_col} < 5'(COLS));

    // One-step shift of the whole grid; the entering line is the
    // departing one when wrapping, zero otherwise.
    always_comb begin
        shifted    = grid_q;
        discard_nz = 1'b0;
        if (bus.shift_en) begin
            unique case (bus.shift_dir)
                DIR_UP: begin
                    for (int r = 0; r < ROWS - 1; r++) begin
                        shifted[r*COLS +: COLS] = grid_q[(r+1)*COLS +: COLS];
                    end
                    shifted[(ROWS-1)*COLS +: COLS] = WRAP ? top_row : '0;
                    discard_nz = |top_row;
                end
                DIR_DOWN: begin
                    for (int r = 1; r < ROWS; r++) begin
                        shifted[r*COLS +: COLS] = grid_q[(r-1)*COLS +: COLS];
                    end
                    shifted[0 +: COLS] = WRAP ? bot_row : '0;
                    discard_nz = |bot_row;
                end
                DIR_LEFT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS - 1; c++) begin
                            shifted[r*COLS + c] = grid_q[r*COLS + c + 1];
                        end
                        shifted[r*COLS + COLS - 1] = WRAP & left_col[r];
                    end
                    discard_nz = |left_col;
                end
                DIR_RIGHT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 1; c < COLS; c++) begin
                            shifted[r*COLS + c] = grid_q[r*COLS + c - 1];
                        end
                        shifted[r*COLS] = WRAP & right_col[r];
                    end
                    discard_nz = |right_col;
                end
                default: ;
            endcase
        end
    end

    // The write lands on the post-shift grid; hit is that cell's value
    // just before the write, which drives collision detection.
    always_comb begin
        grid_d = shifted;
        hit    = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (bus.set && in_range
                    && bus.set_row == 4'(r)
                    && bus.set_col == 4'(c)) begin
                    hit = shifted[r*COLS + c];
                    grid_d[r*COLS + c] = bus.set_value;
                end
            end
        end
        if (bus.clear) begin
            grid_d = '0;
        end
    end

    always_comb begin
        out_up_d    = out_up_q;
        out_down_d  = out_down_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        if (do_shift) begin
            unique case (bus.shift_dir)
                DIR_UP:    out_up_d    = top_row;
                DIR_DOWN:  out_down_d  = bot_row;
                DIR_LEFT:  out_left_d  = left_col;
                DIR_RIGHT: out_right_d = right_col;
                default: ;
            endcase
        end
    end

    assign collision_d = collision_q
                       | (do_set & in_range & bus.set_value & hit);
    assign lost_d      = lost_q | (do_shift & ~WRAP & discard_nz);
    assign addr_err_d  = do_set & ~in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q      <= '0;
            out_up_q    <= '0;
            out_down_q  <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            collision_q <= 1'b0;
            lost_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            grid_q      <= grid_d;
            out_up_q    <= out_up_d;
            out_down_q  <= out_down_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            collision_q <= collision_d;
            lost_q      <= lost_d;
            addr_err_q  <= addr_err_d;
        end
    end

    grid_popcount #(
        .W  (N),
        .CW (COUNT_W)
    ) u_popcount (
        .bits_i  (grid_q),
        .count_o (bus.ones_count)
    );

    assign bus.data_out  = grid_q;
    assign bus.out_up    = out_up_q;
    assign bus.out_down  = out_down_q;
    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign bus.collision = collision_q;
    assign bus.lost      = lost_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_grid_shift_store.sv
// Testbench for grid_shift_store: three instances (4x4 wrap, 4x4 fill,
// 3x5 fill) driven in lockstep and compared against a cell-array model.
module tb_grid_shift_store;

    logic       clk;
    logic       rst_n;
    logic       clear, shift_en, set, val;
    logic [1:0] dir;
    logic [3:0] row, col;

    int n_cmp = 0;
    int n_err = 0;

    grid_shift_store_if #(.ROWS(4), .COLS(4)) ifa ();
    grid_shift_store_if #(.ROWS(4), .COLS(4)) ifb ();
    grid_shift_store_if #(.ROWS(3), .COLS(5)) ifc ();

    grid_shift_store #(.ROWS(4), .COLS(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(rst_n), .bus(ifa));
    grid_shift_store #(.ROWS(4), .COLS(4), .WRAP(1'b0)) dut_b (
        .clk(clk), .reset(rst_n), .bus(ifb));
    grid_shift_store #(.ROWS(3), .COLS(5), .WRAP(1'b0)) dut_c (
        .clk(clk), .reset(rst_n), .bus(ifc));

    assign ifa.clear = clear;    assign ifb.clear = clear;    assign ifc.clear = clear;
    assign ifa.shift_en = shift_en; assign ifb.shift_en = shift_en; assign ifc.shift_en = shift_en;
    assign ifa.shift_dir = dir;  assign ifb.shift_dir = dir;  assign ifc.shift_dir = dir;
    assign ifa.set = set;        assign ifb.set = set;        assign ifc.set = set;
    assign ifa.set_row = row;    assign ifb.set_row = row;    assign ifc.set_row = row;
    assign ifa.set_col = col;    assign ifb.set_col = col;    assign ifc.set_col = col;
    assign ifa.set_value = val;  assign ifb.set_value = val;  assign ifc.set_value = val;

    logic [63:0] obs [3][9];
    assign obs[0][0] = 64'(ifa.data_out);
    assign obs[0][1] = 64'(ifa.out_up);
    assign obs[0][2] = 64'(ifa.out_down);
    assign obs[0][3] = 64'(ifa.out_left);
    assign obs[0][4] = 64'(ifa.out_right);
    assign obs[0][5] = 64'(ifa.ones_count);
    assign obs[0][6] = 64'(ifa.collision);
    assign obs[0][7] = 64'(ifa.lost);
    assign obs[0][8] = 64'(ifa.addr_err);
    assign obs[1][0] = 64'(ifb.data_out);
    assign obs[1][1] = 64'(ifb.out_up);
    assign obs[1][2] = 64'(ifb.out_down);
    assign obs[1][3] = 64'(ifb.out_left);
    assign obs[1][4] = 64'(ifb.out_right);
    assign obs[1][5] = 64'(ifb.ones_count);
    assign obs[1][6] = 64'(ifb.collision);
    assign obs[1][7] = 64'(ifb.lost);
    assign obs[1][8] = 64'(ifb.addr_err);
    assign obs[2][0] = 64'(ifc.data_out);
    assign obs[2][1] = 64'(ifc.out_up);
    assign obs[2][2] = 64'(ifc.out_down);
    assign obs[2][3] = 64'(ifc.out_left);
    assign obs[2][4] = 64'(ifc.out_right);
    assign obs[2][5] = 64'(ifc.ones_count);
    assign obs[2][6] = 64'(ifc.collision);
    assign obs[2][7] = 64'(ifc.lost);
    assign obs[2][8] = 64'(ifc.addr_err);

    // Reference model: plain cell arrays, one per instance.
    int R [3] = '{4, 4, 3};
    int C [3] = '{4, 4, 5};
    bit W [3] = '{1'b1, 1'b0, 1'b0};
    bit g  [3][16][16];
    bit mo [3][4][16];
    bit mcoll [3];
    bit mlost [3];
    bit maerr [3];

    string fname [9] = '{"data", "out_up", "out_down", "out_left",
                         "out_right", "ones", "collision", "lost", "addr_err"};
    string dname [3] = '{"A", "B", "C"};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) g[k][r][c] = 1'b0;
            for (int d = 0; d < 4; d++)
                for (int i = 0; i < 16; i++) mo[k][d][i] = 1'b0;
            mcoll[k] = 1'b0;
            mlost[k] = 1'b0;
            maerr[k] = 1'b0;
        end
    endtask

    // New cell (r,c) takes old (r+dr, c+dc); a source that falls off the
    // grid is the departing line, wrapped around or replaced by zero.
    task automatic model_step();
        bit old [16][16];
        int dr, dc, sr, sc, d;
        bit wr;
        for (int k = 0; k < 3; k++) begin
            if (clear) begin
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) g[k][r][c] = 1'b0;
                maerr[k] = 1'b0;
            end else begin
                old = g[k];
                if (shift_en) begin
                    d  = int'(dir);
                    dr = (d == 0) ? 1 : (d == 1) ? -1 : 0;
                    dc = (d == 2) ? 1 : (d == 3) ? -1 : 0;
                    for (int r = 0; r < R[k]; r++) begin
                        for (int c = 0; c < C[k]; c++) begin
                            sr = r + dr;
                            sc = c + dc;
                            wr = (sr < 0) || (sr >= R[k]) || (sc < 0) || (sc >= C[k]);
                            sr = (sr + R[k]) % R[k];
                            sc = (sc + C[k]) % C[k];
                            g[k][r][c] = (wr && !W[k]) ? 1'b0 : old[sr][sc];
                            if (wr) begin
                                mo[k][d][(dr != 0) ? c : r] = old[sr][sc];
                                if (!W[k] && old[sr][sc]) mlost[k] = 1'b1;
                            end
                        end
                    end
                end
                maerr[k] = 1'b0;
                if (set) begin
                    if (int'(row) < R[k] && int'(col) < C[k]) begin
                        if (val && g[k][row][col]) mcoll[k] = 1'b1;
                        g[k][row][col] = val;
                    end else begin
                        maerr[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [63:0] expv(int k, int j);
        logic [63:0] v = '0;
        int n = 0;
        case (j)
            0: for (int r = 0; r < R[k]; r++)
                   for (int c = 0; c < C[k]; c++) v[r*C[k] + c] = g[k][r][c];
            1, 2: for (int i = 0; i < C[k]; i++) v[i] = mo[k][j-1][i];
            3, 4: for (int i = 0; i < R[k]; i++) v[i] = mo[k][j-1][i];
            5: begin
                for (int r = 0; r < R[k]; r++)
                    for (int c = 0; c < C[k]; c++) n += int'(g[k][r][c]);
                v = 64'(n);
            end
            6: v = 64'(mcoll[k]);
            7: v = 64'(mlost[k]);
            default: v = 64'(maerr[k]);
        endcase
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 9; j++)
                chk($sformatf("%s.%s", dname[k], fname[j]), obs[k][j], expv(k, j));
    endtask

    task automatic idle();
        clear = 1'b0; shift_en = 1'b0; set = 1'b0;
        dir = 2'b00; row = 4'd0; col = 4'd0; val = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    task automatic do_set(int r, int c, bit v);
        idle();
        set = 1'b1; row = 4'(r); col = 4'(c); val = v;
        step();
    endtask

    task automatic do_shift(int d);
        idle();
        shift_en = 1'b1; dir = 2'(d);
        step();
    endtask

    task automatic pulse_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around round trip of one cell.
        do_set(0, 0, 1'b1);
        for (int i = 0; i < 4; i++) do_shift(0);
        chk("wrap_cell00", 64'(ifa.data_out[0]), 64'd1);
        chk("wrap_ones", 64'(ifa.ones_count), 64'd1);
        chk("wrap_lost", 64'(ifa.lost), 64'd0);

        // Zero-fill right shift loses the cell.
        pulse_reset();
        do_set(0, 3, 1'b1);
        do_shift(3);
        chk("fill_data", 64'(ifb.data_out), 64'd0);
        chk("fill_out_right", 64'(ifb.out_right), 64'b0001);
        chk("fill_lost", 64'(ifb.lost), 64'd1);
        chk("fill_ones", 64'(ifb.ones_count), 64'd0);

        // Double write collides; clear keeps the sticky flag.
        pulse_reset();
        do_set(2, 2, 1'b1);
        do_set(2, 2, 1'b1);
        chk("coll_set", 64'(ifa.collision), 64'd1);
        idle(); clear = 1'b1; step();
        chk("coll_clear_data", 64'(ifa.data_out), 64'd0);
        chk("coll_clear_flag", 64'(ifa.collision), 64'd1);

        // Write lands on the post-shift grid.
        pulse_reset();
        do_set(0, 1, 1'b1);
        idle();
        shift_en = 1'b1; dir = 2'b01;
        set = 1'b1; row = 4'd1; col = 4'd1; val = 1'b1;
        step();
        chk("post_shift_data", 64'(ifa.data_out), 64'h0020);
        chk("post_shift_coll", 64'(ifa.collision), 64'd1);
        chk("post_shift_ones", 64'(ifa.ones_count), 64'd1);

        // Out-of-range write pulses addr_err for a single cycle.
        pulse_reset();
        do_set(5, 0, 1'b1);
        chk("aerr_pulse", 64'(ifa.addr_err), 64'd1);
        chk("aerr_grid", 64'(ifa.data_out), 64'd0);
        idle(); step();
        chk("aerr_drop", 64'(ifa.addr_err), 64'd0);

        // Random traffic.
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            clear    = ($urandom_range(0, 15) == 0);
            shift_en = $urandom_range(0, 1) == 1;
            dir      = 2'($urandom_range(0, 3));
            set      = $urandom_range(0, 1) == 1;
            row      = 4'($urandom_range(0, 5));
            col      = 4'($urandom_range(0, 5));
            val      = ($urandom_range(0, 3) != 0);
            step();
        end

        // Full grid, then asynchronous reset between edges.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) do_set(r, c, 1'b1);
        chk("full_ones", 64'(ifa.ones_count), 64'd16);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_data", 64'(ifa.data_out), 64'd0);
        chk("async_ones", 64'(ifa.ones_count), 64'd0);
        check_all();
        shift_en = 1'b1; dir = 2'b10;
        set = 1'b1; row = 4'd1; col = 4'd2; val = 1'b1;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        do_set(1, 2, 1'b1);
        chk("after_reset_data", 64'(ifa.data_out), 64'h0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grid_shift_store.md
GRID_SHIFT_STORE -- requirements
Module: grid_shift_store

Interface
REQ-001 Parameter ROWS, default 8, number of grid rows (2..16).
REQ-002 Parameter COLS, default 8, number of grid columns (2..16).
REQ-003 Parameter WRAP, default 1: 1 = shifted-out line re-enters at the opposite edge; 0 = zero fill.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous grid clear.
REQ-007 shift_en  input  1  perform one shift this cycle.
REQ-008 shift_dir  input  2  shift direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 set  input  1  write set_value into the addressed cell this cycle.
REQ-010 set_row  input  4  row address of the write.
REQ-011 set_col  input  4  column address of the write.
REQ-012 set_value  input  1  value written.
REQ-013 data_out  output  ROWS*COLS  grid; cell (r,c) at bit r*COLS+c; row 0 top, column 0 left.
REQ-014 out_up / out_down  output  COLS each  row last shifted out of the top / bottom edge.
REQ-015 out_left / out_right  output  ROWS each  column last shifted out of the left / right edge.
REQ-016 ones_count  output  9  number of 1 cells in data_out.
REQ-017 collision  output  1  sticky: a set with set_value=1 hit a cell already 1.
REQ-018 lost  output  1  sticky: with WRAP=0, a 1 was shifted off the grid.
REQ-019 addr_err  output  1  one-cycle pulse: set with set_row>=ROWS or set_col>=COLS.

Function
REQ-020 Up: (r,c) <= (r+1,c); out_up <= old row 0; row ROWS-1 <= old row 0 (WRAP=1) or 0.
REQ-021 Down: (r,c) <= (r-1,c); out_down <= old row ROWS-1; row 0 <= old row ROWS-1 (WRAP=1) or 0.
REQ-022 Left: (r,c) <= (r,c+1); out_left <= old column 0; column COLS-1 <= old column 0 (WRAP=1) or 0.
REQ-023 Right: (r,c) <= (r,c-1); out_right <= old column COLS-1; column 0 <= old column COLS-1 (WRAP=1) or 0.
REQ-024 Each out_* register updates only on a shift in its own direction and holds otherwise.
REQ-025 Per-cycle priority: clear, then shift, then set; with clear=1, shift and set are ignored and the grid becomes all 0.
REQ-026 With shift_en and set in one cycle, the write lands at the addressed cell of the post-shift grid.
REQ-027 Writes are visible on data_out one cycle after the sampling edge; there are no other latencies.
REQ-028 ones_count is combinational from the grid register, range 0..ROWS*COLS.
REQ-029 collision sets when the addressed pre-write cell (post-shift) is 1 and set_value=1; only reset clears it.
REQ-030 lost sets in a WRAP=0 shift cycle whose discarded line is non-zero; only reset clears it; never sets when WRAP=1.
REQ-031 An out-of-range set leaves the grid unchanged, pulses addr_err, and does not affect collision.
REQ-032 clear does not affect collision, lost or out_*.

Reset
REQ-033 When reset is low, the grid, all out_*, collision, lost and addr_err go to 0 immediately; ones_count reads 0.
REQ-034 Reset asserted mid-sequence aborts any same-cycle shift or set; the first edge after release behaves per REQ-025.

Structure
REQ-035 Package grid_pkg holds the direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT and the default ROWS/COLS.
REQ-036 The population count is a sub-module, grid_popcount, parametrised by its input width.

Verification
REQ-037 ROWS=COLS=4, WRAP=1: set (0,0)=1, then 4 up shifts -> cell (0,0) returns to 1 after the 4th; ones_count stays 1; lost=0.
REQ-038 WRAP=0: set (0,3)=1, then 1 right shift -> data_out=0, out_right=4'b0001, lost=1, ones_count=0.
REQ-039 Set (2,2)=1 twice with set_value=1 -> collision=1 after the second write; a following clear -> grid 0, collision still 1.
REQ-040 Set (1,1) together with a down shift on a grid whose only 1 is at (0,1) -> cells (1,1) set, collision=1, ones_count=1.
REQ-041 Set row 5 on a 4x4 grid -> addr_err high for exactly one cycle; grid unchanged.
REQ-042 Assert reset low between edges with a full grid -> all outputs 0 at once, with no clock edge needed.
